// File: rtl/vector_output_drain.sv
// Vector output drain: buffers full-width CPU result vectors and streams them out one element per handshake.
// Optional macro VEC_DRAIN_DROP_COUNT_EN adds a saturating 16-bit dropped-vector counter port.
module vector_output_drain #(
    parameter int DATA_WIDTH  = 19,
    parameter int VECTOR_SIZE = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int PTR_WIDTH   = 2,
    parameter int IDX_WIDTH   = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              outFlag,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] out,
    output logic                              stallOut,
    output logic [DATA_WIDTH-1:0]             elemData,
    output logic [IDX_WIDTH-1:0]              elemIndex,
    output logic                              elemValid,
    input  logic                              elemReady,
    output logic                              elemLast,
    output logic                              busy
`ifdef VEC_DRAIN_DROP_COUNT_EN
    ,
    output logic [15:0]                       dropCount
`endif
);
    localparam int VEC_W = VECTOR_SIZE * DATA_WIDTH;
    localparam logic [PTR_WIDTH:0] FULL_CNT  = (PTR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH:0] STALL_CNT = (PTR_WIDTH+1)'(FIFO_DEPTH - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(VECTOR_SIZE - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state_q, state_d;
    logic [VEC_W-1:0]       mem_q [FIFO_DEPTH];
    logic [VEC_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]     count_q, count_d;
    logic [IDX_WIDTH-1:0]   index_q, index_d;
    logic                   stall_q, stall_d;
    logic                   handshake, pop, push;
    logic [DATA_WIDTH-1:0]  rd_elems [VECTOR_SIZE];

    always_comb begin
        handshake = (state_q == STREAM) && elemReady;
        pop       = handshake && (index_q == LAST_IDX);
        // A full FIFO still accepts a vector when the head leaves at the same edge.
        push      = outFlag && ((count_q != FULL_CNT) || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        index_d  = index_q;
        state_d  = state_q;

        if (push) begin
            mem_d[wr_ptr_q] = out;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{PTR_WIDTH{1'b0}}, push} - {{PTR_WIDTH{1'b0}}, pop};

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = STREAM;
                    index_d = '0;
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (pop) begin
                        index_d = '0;
                        if (count_d == '0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // One slot of slack covers the strobe already in flight when the CPU sees the stall.
        stall_d = (count_d >= STALL_CNT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            index_q  <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            index_q  <= index_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int k = 0; k < VECTOR_SIZE; k++) begin
            rd_elems[k] = mem_q[rd_ptr_q][k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign elemValid = (state_q == STREAM);
    assign elemIndex = index_q;
    assign elemData  = elemValid ? rd_elems[index_q] : '0;
    assign elemLast  = elemValid && (index_q == LAST_IDX);
    assign busy      = (count_q != '0) || (state_q == STREAM);
    assign stallOut  = stall_q;

`ifdef VEC_DRAIN_DROP_COUNT_EN
    logic        drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop       = outFlag && !push;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dropCount = drop_cnt_q;
`endif
endmodule
